// File: rtl/sram_d_obi_arbiter.sv
// Two-master OBI arbiter for the data-side SRAM port. It keeps an in-order owner FIFO so each response returns to its issuer.
// Optional: define SRAM_ARB_FIXED_PRIO_EN to make master 0 always win contention. The default build uses round-robin.
module sram_d_obi_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  m_req_i,
    output logic [1:0]  m_gnt_o,
    input  logic [63:0] m_addr_i,
    input  logic [1:0]  m_we_i,
    input  logic [7:0]  m_be_i,
    input  logic [63:0] m_wdata_i,
    output logic [1:0]  m_rvalid_o,
    output logic [31:0] m_rdata_o,
    output logic [1:0]  m_err_o,
    output logic        slv_req_o,
    input  logic        slv_gnt_i,
    output logic [31:0] slv_addr_o,
    output logic        slv_we_o,
    output logic [3:0]  slv_be_o,
    output logic [31:0] slv_wdata_o,
    input  logic        slv_rvalid_i,
    input  logic [31:0] slv_rdata_i,
    input  logic        slv_illegal_i,
    output logic        protocol_err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic                       sel;
    logic                       any_req;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       head_owner;
    logic                       head_err;
    logic [CNT_W-1:0]           count;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [MAX_OUTSTANDING-1:0] err_q;

    assign any_req = |m_req_i;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign sel = ~m_req_i[0];
`else
    logic rr_ptr;
    logic both_req;

    assign both_req = &m_req_i;
    assign sel      = both_req ? rr_ptr : m_req_i[1];

    // Hand priority to the other master only after a contended handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr <= 1'b0;
        end else if (push && both_req) begin
            rr_ptr <= ~sel;
        end
    end
`endif

    // A full FIFO blocks forwarding even when a pop happens in the same cycle.
    assign slv_req_o   = any_req & ~full;
    assign slv_addr_o  = sel ? m_addr_i[63:32]  : m_addr_i[31:0];
    assign slv_we_o    = sel ? m_we_i[1]        : m_we_i[0];
    assign slv_be_o    = sel ? m_be_i[7:4]      : m_be_i[3:0];
    assign slv_wdata_o = sel ? m_wdata_i[63:32] : m_wdata_i[31:0];

    assign push    = slv_req_o & slv_gnt_i;
    assign m_gnt_o = {push & sel, push & ~sel};

    assign pop        = slv_rvalid_i & ~empty;
    assign head_owner = owner_q[rd_ptr];
    assign head_err   = err_q[rd_ptr];
    assign m_rvalid_o = {pop & head_owner, pop & ~head_owner};
    assign m_err_o    = {pop & head_owner & head_err, pop & ~head_owner & head_err};
    assign m_rdata_o  = slv_rdata_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wr_ptr] <= sel;
                err_q[wr_ptr]   <= slv_illegal_i;
                wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            // A response with nothing outstanding is dropped and flagged until reset.
            if (slv_rvalid_i && empty) begin
                protocol_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_d_obi_arbiter.sv
// Scoreboard bench for sram_d_obi_arbiter: directed master traffic against a small SRAM model with adjustable latency.
module tb_sram_d_obi_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  m_req_i = '0;
    logic [1:0]  m_gnt_o;
    logic [63:0] m_addr_i = '0;
    logic [1:0]  m_we_i = '0;
    logic [7:0]  m_be_i = '0;
    logic [63:0] m_wdata_i = '0;
    logic [1:0]  m_rvalid_o;
    logic [31:0] m_rdata_o;
    logic [1:0]  m_err_o;
    logic        slv_req_o;
    logic        slv_gnt_i = 1'b1;
    logic [31:0] slv_addr_o;
    logic        slv_we_o;
    logic [3:0]  slv_be_o;
    logic [31:0] slv_wdata_o;
    logic        slv_rvalid_i = 1'b0;
    logic [31:0] slv_rdata_i = '0;
    logic        slv_illegal_i;
    logic        protocol_err_o;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        int          rem;
        logic [31:0] data;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] mem [0:63];
    logic [63:0] written = '0;
    int          lat = 1;
    int          orphan_cnt = 0;
    int          orphan_done = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Addresses below 0x1000 are illegal in this SRAM model.
    assign slv_illegal_i = slv_req_o && (slv_addr_o < 32'h0000_1000);

    sram_d_obi_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .m_req_i        (m_req_i),
        .m_gnt_o        (m_gnt_o),
        .m_addr_i       (m_addr_i),
        .m_we_i         (m_we_i),
        .m_be_i         (m_be_i),
        .m_wdata_i      (m_wdata_i),
        .m_rvalid_o     (m_rvalid_o),
        .m_rdata_o      (m_rdata_o),
        .m_err_o        (m_err_o),
        .slv_req_o      (slv_req_o),
        .slv_gnt_i      (slv_gnt_i),
        .slv_addr_o     (slv_addr_o),
        .slv_we_o       (slv_we_o),
        .slv_be_o       (slv_be_o),
        .slv_wdata_o    (slv_wdata_o),
        .slv_rvalid_i   (slv_rvalid_i),
        .slv_rdata_i    (slv_rdata_i),
        .slv_illegal_i  (slv_illegal_i),
        .protocol_err_o (protocol_err_o)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int k, input logic req, input logic [31:0] addr,
                                  input logic we, input logic [31:0] wdata);
        m_req_i[k]            = req;
        m_we_i[k]             = we;
        m_addr_i[k*32 +: 32]  = addr;
        m_be_i[k*4 +: 4]      = 4'hF;
        m_wdata_i[k*32 +: 32] = wdata;
    endtask

    task automatic push_exp(input logic owner, input logic [31:0] data, input logic err, input int due);
        exp_q.push_back('{owner: owner, data: data, err: err, due: due});
    endtask

    // Slave side: capture handshakes mid-cycle and answer them after lat cycles.
    task automatic slave_req_loop();
        logic [5:0]  idx;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                pend_q.delete();
            end else if (slv_req_o && slv_gnt_i) begin
                idx = slv_addr_o[7:2];
                if (slv_illegal_i) begin
                    d = 32'hDEAD_BEEF;
                end else if (slv_we_o) begin
                    mem[idx]     = slv_wdata_o;
                    written[idx] = 1'b1;
                    d            = 32'h0;
                end else begin
                    d = written[idx] ? mem[idx] : (32'hA500_0000 | {26'b0, idx});
                end
                pend_q.push_back('{rem: lat, data: d});
            end
        end
    endtask

    task automatic slave_rsp_loop();
        forever begin
            step();
            slv_rvalid_i = 1'b0;
            slv_rdata_i  = 32'h0;
            foreach (pend_q[i]) pend_q[i].rem = pend_q[i].rem - 1;
            if (orphan_cnt != orphan_done) begin
                slv_rvalid_i = 1'b1;
                slv_rdata_i  = 32'h0BAD_0BAD;
                orphan_done++;
            end else if (pend_q.size() != 0 && pend_q[0].rem <= 0) begin
                slv_rvalid_i = 1'b1;
                slv_rdata_i  = pend_q[0].data;
                void'(pend_q.pop_front());
            end
        end
    endtask

    task automatic monitor_loop();
        exp_t       e;
        logic [1:0] v;
        logic [1:0] er;
        forever begin
            @(negedge clk);
            if (m_rvalid_o != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_rvalid", 64'(m_rvalid_o), 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    v  = e.owner ? 2'b10 : 2'b01;
                    er = e.err ? v : 2'b00;
                    check_output("rsp_valid_err_data", {28'b0, m_rvalid_o, m_err_o, m_rdata_o},
                                 {28'b0, v, er, e.data});
                    check_output("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    endtask

    initial begin
        fork
            slave_req_loop();
            slave_rsp_loop();
            monitor_loop();
        join_none

        step();
        step();
        rst_ni = 1'b1;
        @(negedge clk);
        check_output("reset_gnt", 64'(m_gnt_o), 64'd0);
        check_output("reset_rvalid", 64'(m_rvalid_o), 64'd0);
        check_output("reset_slv_req", 64'(slv_req_o), 64'd0);
        check_output("reset_perr", 64'(protocol_err_o), 64'd0);

        // Contention with 1-cycle latency: grants alternate 0,1,0,1.
        step();
        t = cyc;
        push_exp(1'b0, 32'hA500_0008, 1'b0, t + 1);
        push_exp(1'b1, 32'hA500_0009, 1'b0, t + 2);
        push_exp(1'b0, 32'hA500_000A, 1'b0, t + 3);
        push_exp(1'b1, 32'hA500_000B, 1'b0, t + 4);
        apply_stimulus(0, 1'b1, 32'h8000_0020, 1'b0, 32'h0);
        apply_stimulus(1, 1'b1, 32'h8000_0024, 1'b0, 32'h0);
        @(negedge clk);
        check_output("rr_gnt_a", 64'(m_gnt_o), 64'(2'b01));
        step();
        apply_stimulus(0, 1'b1, 32'h8000_0028, 1'b0, 32'h0);
        @(negedge clk);
        check_output("rr_gnt_b", 64'(m_gnt_o), 64'(2'b10));
        step();
        apply_stimulus(1, 1'b1, 32'h8000_002C, 1'b0, 32'h0);
        @(negedge clk);
        check_output("rr_gnt_c", 64'(m_gnt_o), 64'(2'b01));
        step();
        apply_stimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check_output("rr_gnt_d", 64'(m_gnt_o), 64'(2'b10));
        step();
        apply_stimulus(1, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) step();

        // Master 1 writes, master 0 reads the same word back.
        t = cyc;
        apply_stimulus(1, 1'b1, 32'h8000_0010, 1'b1, 32'hCAFE_F00D);
        push_exp(1'b1, 32'h0, 1'b0, t + 1);
        @(negedge clk);
        check_output("wr_gnt", 64'(m_gnt_o), 64'(2'b10));
        step();
        apply_stimulus(1, 1'b0, 32'h0, 1'b0, 32'h0);
        apply_stimulus(0, 1'b1, 32'h8000_0010, 1'b0, 32'h0);
        push_exp(1'b0, 32'hCAFE_F00D, 1'b0, t + 2);
        @(negedge clk);
        check_output("rd_gnt", 64'(m_gnt_o), 64'(2'b01));
        step();
        apply_stimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) step();

        // Illegal address returns an error to master 0.
        t = cyc;
        apply_stimulus(0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        push_exp(1'b0, 32'hDEAD_BEEF, 1'b1, t + 1);
        @(negedge clk);
        check_output("illegal_gnt", 64'(m_gnt_o), 64'(2'b01));
        step();
        apply_stimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) step();

        // Latency 3 fills the FIFO; the next grant waits one cycle past the first pop.
        lat = 3;
        t = cyc;
        push_exp(1'b0, 32'hA500_000C, 1'b0, t + 3);
        push_exp(1'b0, 32'hA500_000D, 1'b0, t + 4);
        push_exp(1'b0, 32'hA500_000E, 1'b0, t + 7);
        apply_stimulus(0, 1'b1, 32'h8000_0030, 1'b0, 32'h0);
        @(negedge clk);
        check_output("full_gnt_a", 64'(m_gnt_o), 64'(2'b01));
        step();
        apply_stimulus(0, 1'b1, 32'h8000_0034, 1'b0, 32'h0);
        @(negedge clk);
        check_output("full_gnt_b", 64'(m_gnt_o), 64'(2'b01));
        step();
        apply_stimulus(0, 1'b1, 32'h8000_0038, 1'b0, 32'h0);
        @(negedge clk);
        check_output("full_block", 64'({slv_req_o, m_gnt_o}), 64'd0);
        step();
        @(negedge clk);
        check_output("full_block_on_pop", 64'({slv_req_o, m_gnt_o}), 64'd0);
        step();
        @(negedge clk);
        check_output("full_regrant", 64'(m_gnt_o), 64'(2'b01));
        step();
        apply_stimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) step();
        lat = 1;

        // Orphan response sets a sticky flag that only reset clears.
        t = cyc;
        @(negedge clk);
        orphan_cnt++;
        step();
        @(negedge clk);
        check_output("orphan_rvalid", 64'(m_rvalid_o), 64'd0);
        step();
        apply_stimulus(1, 1'b1, 32'h8000_0040, 1'b0, 32'h0);
        push_exp(1'b1, 32'hA500_0010, 1'b0, t + 3);
        @(negedge clk);
        check_output("perr_set", 64'(protocol_err_o), 64'd1);
        check_output("post_orphan_gnt", 64'(m_gnt_o), 64'(2'b10));
        step();
        apply_stimulus(1, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        @(negedge clk);
        check_output("perr_sticky", 64'(protocol_err_o), 64'd1);
        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        @(negedge clk);
        check_output("perr_cleared", 64'(protocol_err_o), 64'd0);

        // Reset with two entries outstanding and rr_ptr pointing at master 1.
        lat = 3;
        step();
        t = cyc;
        apply_stimulus(0, 1'b1, 32'h8000_0050, 1'b0, 32'h0);
        apply_stimulus(1, 1'b1, 32'h8000_0054, 1'b0, 32'h0);
        @(negedge clk);
        check_output("pre_rst_gnt_a", 64'(m_gnt_o), 64'(2'b01));
        step();
        apply_stimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check_output("pre_rst_gnt_b", 64'(m_gnt_o), 64'(2'b10));
        step();
        apply_stimulus(1, 1'b0, 32'h0, 1'b0, 32'h0);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        apply_stimulus(0, 1'b1, 32'h8000_0058, 1'b0, 32'h0);
        apply_stimulus(1, 1'b1, 32'h8000_005C, 1'b0, 32'h0);
        push_exp(1'b0, 32'hA500_0016, 1'b0, t + 6);
        @(negedge clk);
        check_output("post_rst_gnt_a", 64'(m_gnt_o), 64'(2'b01));
        step();
        apply_stimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
        push_exp(1'b1, 32'hA500_0017, 1'b0, t + 7);
        @(negedge clk);
        check_output("post_rst_gnt_b", 64'(m_gnt_o), 64'(2'b10));
        step();
        apply_stimulus(1, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (5) step();

        check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
